// File: rtl/skip_counter_pkg.sv
// Shared constants for the skip-sequence counter and its run controller.
package skip_counter_pkg;

  // Controller state encodings (also driven onto the state output).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Default sequence shape: 0..4 then 11..15, wrapping to 0.
  localparam int         WIDTH_DEF     = 4;
  localparam int         SKIP_FROM_DEF = 4;
  localparam int         SKIP_TO_DEF   = 11;
  localparam logic [3:0] TOP_DEF       = 4'hF;

endpackage

// File: rtl/skip_seq_counter.sv
// Enable-driven skip-sequence counter: SKIP_FROM jumps to SKIP_TO, all-ones wraps to 0.
module skip_seq_counter
  import skip_counter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SKIP_FROM = SKIP_FROM_DEF,
  parameter int SKIP_TO   = SKIP_TO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] z,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] FROM_V = WIDTH'(SKIP_FROM);
  localparam logic [WIDTH-1:0] TO_V   = WIDTH'(SKIP_TO);
  localparam logic [WIDTH-1:0] TOP_V  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] z_d, z_q;
  logic             wrap_d, wrap_q;

  // Next count; values inside the skipped gap recover to 0 without a wrap.
  always_comb begin
    z_d    = z_q;
    wrap_d = 1'b0;
    if (clr) begin
      z_d = '0;
    end else if (en) begin
      if (z_q == FROM_V) begin
        z_d = TO_V;
      end else if (z_q == TOP_V) begin
        z_d    = '0;
        wrap_d = 1'b1;
      end else if ((z_q > FROM_V) && (z_q < TO_V)) begin
        z_d = '0;
      end else begin
        z_d = z_q + WIDTH'(1);
      end
    end
  end

  // Count and wrap registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      z_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      z_q    <= z_d;
      wrap_q <= wrap_d;
    end
  end

  assign z    = z_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/skip_counter_ctrl.sv
// Run controller for the skip-sequence counter: start/stop/step, prescaler, loop count.
//
// state | meaning
// IDLE  | stopped, z may be stepped manually
// RUN   | advancing once per prescaler period
// PAUSE | z held, may be stepped, resumed or aborted
// DONE  | one-cycle completion marker, then IDLE
module skip_counter_ctrl
  import skip_counter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SKIP_FROM = SKIP_FROM_DEF,
  parameter int SKIP_TO   = SKIP_TO_DEF,
  parameter int DIV_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       loops,
  output logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] TOP_V = {WIDTH{1'b1}};

  logic [1:0]       state_d, state_q;
  logic [DIV_W-1:0] pre_d, pre_q;
  logic [DIV_W-1:0] div_l_d, div_l_q;
  logic [3:0]       loops_l_d, loops_l_q;
  logic [3:0]       loop_d, loop_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             adv, clr, wrap_now;

  skip_seq_counter #(
    .WIDTH    (WIDTH),
    .SKIP_FROM(SKIP_FROM),
    .SKIP_TO  (SKIP_TO)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (adv),
    .z    (z),
    .wrap (wrap)
  );

  // FSM, prescaler and loop accounting; stop outranks start, which outranks step.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    div_l_d   = div_l_q;
    loops_l_d = loops_l_q;
    loop_d    = loop_q;
    adv       = 1'b0;
    clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (start) begin
            state_d   = ST_RUN;
            clr       = 1'b1;
            pre_d     = '0;
            loop_d    = '0;
            div_l_d   = div;
            loops_l_d = loops;
          end else if (step) begin
            adv = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (pre_q == div_l_q) begin
          adv   = 1'b1;
          pre_d = '0;
        end else begin
          pre_d = pre_q + DIV_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
          pre_d   = '0;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Manual steps in IDLE never count toward the loop total.
    wrap_now = adv && (z == TOP_V);
    if (wrap_now && (state_q != ST_IDLE)) begin
      loop_d = loop_q + 4'd1;
      if ((loops_l_q != 4'd0) && (loop_d == loops_l_q)) begin
        state_d = ST_DONE;
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      div_l_q   <= '0;
      loops_l_q <= '0;
      loop_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      div_l_q   <= div_l_d;
      loops_l_q <= loops_l_d;
      loop_q    <= loop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_skip_counter_ctrl.sv
// Directed self-checking bench for skip_counter_ctrl.
module tb_skip_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, step;
  logic [7:0] div;
  logic [3:0] loops;
  logic [3:0] z;
  logic       busy, wrap, done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int wraps;
  int done_seen;
  logic [3:0] seq [10];

  skip_counter_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .stop (stop),
    .step (step),
    .div  (div),
    .loops(loops),
    .z    (z),
    .busy (busy),
    .wrap (wrap),
    .done (done),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    reset = 1'b0; start = 1'b1; stop = 1'b0; step = 1'b0; div = 8'd0; loops = 4'd0;

    // 1: reset dominates start
    tick(); tick();
    check("rst_z", 32'(z), 0);
    check("rst_state", 32'(state), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b1; start = 1'b0;
    tick();
    check("idle_state", 32'(state), 0);

    // 2: div=0 loops=1, full sequence then DONE
    div = 8'd0; loops = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    check("t2_z0", 32'(z), 0);
    check("t2_state", 32'(state), 1);
    check("t2_busy", 32'(busy), 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t2_z", 32'(z), 32'(seq[i % 10]));
      if (i == 10) begin
        check("t2_wrap", 32'(wrap), 1);
        check("t2_done_state", 32'(state), 3);
        check("t2_done", 32'(done), 1);
        check("t2_done_busy", 32'(busy), 0);
      end else begin
        check("t2_nowrap", 32'(wrap), 0);
      end
    end
    tick();
    check("t2_idle", 32'(state), 0);
    check("t2_done_off", 32'(done), 0);
    check("t2_busy_off", 32'(busy), 0);

    // 3: div=2 loops=0, advance every third cycle, never done
    div = 8'd2; loops = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    wraps = 0; done_seen = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      wraps += int'(wrap);
      done_seen += int'(done);
      check("t3_z", 32'(z), 32'(seq[(k / 3) % 10]));
    end
    check("t3_wraps", 32'(wraps), 2);
    check("t3_done", 32'(done_seen), 0);
    check("t3_state", 32'(state), 1);
    stop = 1'b1;
    tick();
    check("t3_pause", 32'(state), 2);
    tick(); stop = 1'b0;
    check("t3_abort", 32'(state), 0);
    check("t3_abort_z", 32'(z), 0);

    // 4: stop at z=4, step, resume
    div = 8'd0; loops = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("t4_z4", 32'(z), 4);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("t4_pause", 32'(state), 2);
    check("t4_pause_z", 32'(z), 4);
    tick();
    check("t4_hold_z", 32'(z), 4);
    step = 1'b1;
    tick(); step = 1'b0;
    check("t4_step_z", 32'(z), 11);
    check("t4_step_state", 32'(state), 2);
    start = 1'b1;
    tick(); start = 1'b0;
    check("t4_resume", 32'(state), 1);
    check("t4_resume_z", 32'(z), 11);
    tick();
    check("t4_z12", 32'(z), 12);

    // 5: stop beats a due tick; start+stop in IDLE stays IDLE
    stop = 1'b1;
    tick();
    check("t5_pause", 32'(state), 2);
    check("t5_pause_z", 32'(z), 12);
    tick();
    check("t5_abort", 32'(state), 0);
    start = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("t5_ss_state", 32'(state), 0);
    check("t5_ss_z", 32'(z), 0);
    check("t5_ss_busy", 32'(busy), 0);

    // 6: reset mid-run at z=13
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (7) tick();
    check("t6_z13", 32'(z), 13);
    reset = 1'b0;
    tick(); reset = 1'b1;
    check("t6_z", 32'(z), 0);
    check("t6_state", 32'(state), 0);
    check("t6_busy", 32'(busy), 0);
    repeat (3) tick();
    check("t6_still_z", 32'(z), 0);

    // step in IDLE advances once
    step = 1'b1;
    tick(); step = 1'b0;
    check("idle_step_z", 32'(z), 1);
    check("idle_step_state", 32'(state), 0);

    // step-induced wrap in PAUSE completes the last loop
    div = 8'd0; loops = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    check("ps_z15", 32'(z), 15);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("ps_pause_z", 32'(z), 15);
    step = 1'b1;
    tick(); step = 1'b0;
    check("ps_z", 32'(z), 0);
    check("ps_wrap", 32'(wrap), 1);
    check("ps_state", 32'(state), 3);
    check("ps_done", 32'(done), 1);
    tick();
    check("ps_idle", 32'(state), 0);
    check("ps_wrap_off", 32'(wrap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/skip_counter_ctrl.md
Name: skip_counter_ctrl

Overview:
Run controller for the 0-4 / 11-15 skip-sequence counter used in the counter labs. It owns a synchronous, enable-driven skip counter and sequences it. Controls are start, stop and single-step. A programmable prescaler sets the advance rate, and a loop count sets how many full sequences run before the block finishes. Outputs are the count value plus busy, wrap and done status.

Parameters:
WIDTH, 4, counter width; the top value is all ones (15).
SKIP_FROM, 4, count value at which the sequence jumps.
SKIP_TO, 11, value loaded after SKIP_FROM.
DIV_W, 8, prescaler width.

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk
start  input  1  start from IDLE, or resume from PAUSE
stop  input  1  pause from RUN, or abort from PAUSE
step  input  1  single advance in IDLE or PAUSE
div  input  DIV_W  tick period minus 1; latched on start
loops  input  4  sequences to run; 0 = run forever; latched on start
z  output  WIDTH  current count
busy  output  1  high in RUN and PAUSE
wrap  output  1  one-cycle pulse, high in the same cycle z becomes 0 after 15
done  output  1  one-cycle pulse on completion
state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (reset==0 at a clk edge):
  - z=0, state=IDLE, busy=0, wrap=0, done=0.
  - Prescaler, loop counter, latched div and latched loops all clear to 0.
  - Reset overrides every other input, in every state, including mid-run.
- All outputs are registered.
- Command priority: stop > start > step. Non-applicable commands are ignored.
- Advance rule:
  - z==SKIP_FROM -> SKIP_TO.
  - z==15 -> 0, wrap=1, loop counter +1.
  - Any z strictly between SKIP_FROM and SKIP_TO -> 0 (recovery; wrap stays 0).
  - Otherwise z+1.
  - Legal sequence is 0,1,2,3,4,11,12,13,14,15,0, i.e. 10 states.
- IDLE:
  - start: go to RUN; z=0; prescaler=0; loop counter=0; latch div and loops.
  - step: one advance, stay in IDLE; wrap may pulse; the loop counter is not touched.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler==div_latched: tick, i.e. one advance and prescaler=0. The first tick comes div+1 cycles after start. div=0 gives a tick every cycle.
  - stop: go to PAUSE. There is no advance in that cycle, even if a tick was due, and the prescaler holds.
  - Completion: if loops_latched!=0 and a wrap makes the loop counter equal loops_latched, go to DONE in the same edge. z=0 and wrap=1 in that cycle.
- PAUSE:
  - z holds.
  - start: go to RUN; prescaler=0; z unchanged; loop counter unchanged.
  - step: one advance. A wrap here counts toward loops and can trigger DONE.
  - stop: go to IDLE; z=0.
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=0, then returns to IDLE.
  - start in DONE is ignored.
- busy = (state==RUN or state==PAUSE).
- wrap and done are never high for more than one cycle.

Decomposition:
- Package skip_counter_pkg holds:
  - state encodings IDLE, RUN, PAUSE and DONE;
  - defaults for SKIP_FROM, SKIP_TO and the all-ones top value.
- Sub-module skip_seq_counter: a synchronous active-low reset, an en input and a wrap output. It implements the advance rule only.
- The controller holds the FSM, the prescaler and the loop counter.

Test Plan:
1. Hold reset=0 for 2 cycles with start=1 -> z=0, state=IDLE, busy=0, wrap=0, done=0.
2. div=0, loops=1, pulse start -> z reads 0,1,2,3,4,11,12,13,14,15,0 on consecutive cycles. wrap=1 with z=0 on tick 10, state=DONE at that edge, done=1 for one cycle, then IDLE and busy=0.
3. div=2, loops=0, start -> z advances every 3 cycles. After 60 cycles z=0 and wrap has pulsed twice; done is never asserted.
4. RUN with div=0; stop when z=4 -> PAUSE with z=4 held. Then step gives z=11, then start gives RUN and z=12 on the next cycle.
5. Simultaneous start+stop in IDLE -> stays IDLE with z=0. Simultaneous stop+tick in RUN -> PAUSE with z unchanged.
6. In RUN at z=13, drive reset=0 for one edge -> z=0, state=IDLE, busy=0. Without a new start, z stays 0.
